nihilist_stream_cipher: RTL and testbench

//  Streaming, pipelined Nihilist cipher. Encrypts and decrypts over a fixed 5x5 Polybius square (J folded to I).
//  The key is runtime-programmable, up to KEY_MAX characters. One character per beat, with valid/ready in and out.

---
 rtl/nihilist_pkg.sv | 62 ++++++
 rtl/nihilist_stream_cipher_lookup.sv | 19 +
 rtl/nihilist_stream_cipher.sv | 186 ++++++++++++++++++
 tb/tb_nihilist_stream_cipher.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nihilist_pkg.sv
// Shared types, Polybius square and char/code helpers for the Nihilist cipher.
package nihilist_pkg;

  typedef logic [6:0] code_t;

  localparam int unsigned SQ_N         = 5;
  localparam code_t       CODE_INVALID = 7'd0;
  localparam code_t       CODE_R       = 7'd11;
  localparam int unsigned DEF_KEY_LEN  = 7;

  // Rows RAESB / CDFGH / IKLMN / OPQTU / VWXYZ; code = 10*row + col, both 1-based.
  localparam logic [7:0] SQUARE [SQ_N][SQ_N] = '{
    '{8'h52, 8'h41, 8'h45, 8'h53, 8'h42},
    '{8'h43, 8'h44, 8'h46, 8'h47, 8'h48},
    '{8'h49, 8'h4B, 8'h4C, 8'h4D, 8'h4E},
    '{8'h4F, 8'h50, 8'h51, 8'h54, 8'h55},
    '{8'h56, 8'h57, 8'h58, 8'h59, 8'h5A}
  };

  // 'J' folds onto 'I'; anything outside the square maps to CODE_INVALID.
  function automatic code_t char2code(input logic [7:0] ch);
    logic [7:0] c;
    code_t      res;
    c   = (ch == 8'h4A) ? 8'h49 : ch;
    res = CODE_INVALID;
    for (int r = 0; r < SQ_N; r++) begin
      for (int col = 0; col < SQ_N; col++) begin
        if (SQUARE[r][col] == c) res = 7'(10 * (r + 1) + col + 1);
      end
    end
    return res;
  endfunction

  // Equality ladder against the 25 legal codes; returns 8'h00 for any other code.
  function automatic logic [7:0] code2char(input code_t code);
    logic [7:0] res;
    res = 8'h00;
    for (int r = 0; r < SQ_N; r++) begin
      for (int col = 0; col < SQ_N; col++) begin
        if (code == 7'(10 * (r + 1) + col + 1)) res = SQUARE[r][col];
      end
    end
    return res;
  endfunction

  // Reset key "NEDELCU"; unused slots hold 'R'.
  function automatic code_t default_key_code(input int unsigned idx);
    code_t res;
    case (idx)
      0:       res = 7'd35;
      1:       res = 7'd13;
      2:       res = 7'd22;
      3:       res = 7'd13;
      4:       res = 7'd33;
      5:       res = 7'd21;
      6:       res = 7'd45;
      default: res = CODE_R;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/nihilist_stream_cipher_lookup.sv
// Combinational Polybius lookup in both directions.
//  char_i -> code_o / code_valid_o ; code_i -> char_o / char_valid_o
module polybius_lookup
  import nihilist_pkg::*;
(
  input  logic [7:0] char_i,
  output code_t      code_o,
  output logic       code_valid_o,
  input  code_t      code_i,
  output logic [7:0] char_o,
  output logic       char_valid_o
);

  assign code_o       = char2code(char_i);
  assign code_valid_o = (code_o != CODE_INVALID);
  assign char_o       = code2char(code_i);
  assign char_valid_o = (char_o != 8'h00);

endmodule

// File: rtl/nihilist_stream_cipher.sv
// Two-stage streaming Nihilist cipher (encrypt/decrypt) with programmable key.
//  clk/rst                       : clock, synchronous active-high reset
//  key_we/key_addr/key_char/key_len : key slot write, ignored while key_busy
//  mode                          : 0 encrypt, 1 decrypt, latched on first beat
//  s_valid/s_ready/s_data/s_last : input beat stream
//  m_valid/m_ready/m_data/m_last/m_err : output beat stream
module nihilist_stream_cipher
  import nihilist_pkg::*;
#(
  parameter int unsigned KEY_MAX = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         key_we,
  input  logic [$clog2(KEY_MAX)-1:0]   key_addr,
  input  logic [7:0]                   key_char,
  input  logic [$clog2(KEY_MAX+1)-1:0] key_len,
  output logic                         key_busy,
  input  logic                         mode,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [7:0]                   s_data,
  input  logic                         s_last,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [7:0]                   m_data,
  output logic                         m_last,
  output logic                         m_err
);

  localparam int unsigned KA_W  = $clog2(KEY_MAX);
  localparam int unsigned KA1_W = KA_W + 1;
  localparam int unsigned KL_W  = $clog2(KEY_MAX + 1);

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_e;

  state_e            state_q, state_d;
  logic              mode_q, mode_d;
  logic [KL_W-1:0]   k_q, k_d, key_len_q, key_len_d, k_inc;
  code_t             key_ram_q [KEY_MAX];
  code_t             key_ram_d [KEY_MAX];

  logic              s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
  logic              s1_mode_q, s1_mode_d, s1_err_q, s1_err_d;
  logic [7:0]        s1_val_q, s1_val_d;
  code_t             s1_key_q, s1_key_d;

  logic              m_valid_q, m_valid_d, m_last_q, m_last_d, m_err_q, m_err_d;
  logic [7:0]        m_data_q, m_data_d;

  logic              advance, accept, eff_mode;
  code_t             dp_code, kw_code, dec_code;
  logic              dp_code_ok, kw_code_ok, dp_char_ok;
  logic [7:0]        dp_char, enc_sum, dec_diff, res_data;
  logic              dec_under, res_err;
  logic [7:0]        key_lkp_unused_char;
  logic              key_lkp_unused_ok;

  // Data path: char->code before S1, code->char after S1 (decrypt result).
  polybius_lookup u_dp_lookup (
    .char_i       (s_data),
    .code_o       (dp_code),
    .code_valid_o (dp_code_ok),
    .code_i       (dec_code),
    .char_o       (dp_char),
    .char_valid_o (dp_char_ok)
  );

  // Key write conversion; only the char->code direction is needed.
  polybius_lookup u_key_lookup (
    .char_i       (key_char),
    .code_o       (kw_code),
    .code_valid_o (kw_code_ok),
    .code_i       (CODE_INVALID),
    .char_o       (key_lkp_unused_char),
    .char_valid_o (key_lkp_unused_ok)
  );

  assign advance  = !(m_valid_q && !m_ready);
  assign s_ready  = advance;
  assign accept   = s_valid && advance;
  assign key_busy = (state_q == ST_ACTIVE) || s1_valid_q || m_valid_q;
  // The first beat of a message uses the live mode pin; later beats the latched one.
  assign eff_mode = (state_q == ST_IDLE) ? mode : mode_q;
  assign k_inc    = k_q + KL_W'(1);

  // S2 arithmetic; decrypt codes above 55 can never be legal.
  assign enc_sum   = s1_val_q + 8'(s1_key_q);
  assign dec_diff  = s1_val_q - 8'(s1_key_q);
  assign dec_under = s1_val_q < 8'(s1_key_q);
  assign dec_code  = (dec_diff <= 8'd55) ? 7'(dec_diff) : CODE_INVALID;
  assign res_err   = s1_mode_q ? (dec_under || !dp_char_ok) : s1_err_q;
  assign res_data  = res_err ? 8'h00 : (s1_mode_q ? dp_char : enc_sum);

  // Message FSM, key index, key writes and pipeline advance.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    k_d        = k_q;
    key_len_d  = key_len_q;
    key_ram_d  = key_ram_q;
    s1_valid_d = s1_valid_q;
    s1_last_d  = s1_last_q;
    s1_mode_d  = s1_mode_q;
    s1_err_d   = s1_err_q;
    s1_val_d   = s1_val_q;
    s1_key_d   = s1_key_q;
    m_valid_d  = m_valid_q;
    m_last_d   = m_last_q;
    m_err_d    = m_err_q;
    m_data_d   = m_data_q;

    if (accept) begin
      if (state_q == ST_IDLE) mode_d = mode;
      if (s_last) begin
        state_d = ST_IDLE;
        k_d     = '0;
      end else begin
        state_d = ST_ACTIVE;
        k_d     = (k_inc >= key_len_q) ? '0 : k_inc;
      end
    end

    if (key_we && !key_busy && ({1'b0, key_addr} < KA1_W'(KEY_MAX))) begin
      key_ram_d[key_addr] = kw_code_ok ? kw_code : CODE_R;
      if (key_len == '0)                  key_len_d = KL_W'(1);
      else if (key_len > KL_W'(KEY_MAX))  key_len_d = KL_W'(KEY_MAX);
      else                                key_len_d = key_len;
    end

    if (advance) begin
      s1_valid_d = accept;
      s1_last_d  = s_last;
      s1_mode_d  = eff_mode;
      s1_key_d   = key_ram_q[KA_W'(k_q)];
      s1_val_d   = eff_mode ? s_data : {1'b0, dp_code};
      s1_err_d   = !eff_mode && !dp_code_ok;
      m_valid_d  = s1_valid_q;
      m_last_d   = s1_valid_q && s1_last_q;
      m_err_d    = s1_valid_q && res_err;
      m_data_d   = s1_valid_q ? res_data : 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mode_q     <= 1'b0;
      k_q        <= '0;
      key_len_q  <= KL_W'(DEF_KEY_LEN);
      for (int unsigned i = 0; i < KEY_MAX; i++) key_ram_q[i] <= default_key_code(i);
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_mode_q  <= 1'b0;
      s1_err_q   <= 1'b0;
      s1_val_q   <= 8'h00;
      s1_key_q   <= CODE_INVALID;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      m_err_q    <= 1'b0;
      m_data_q   <= 8'h00;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      k_q        <= k_d;
      key_len_q  <= key_len_d;
      key_ram_q  <= key_ram_d;
      s1_valid_q <= s1_valid_d;
      s1_last_q  <= s1_last_d;
      s1_mode_q  <= s1_mode_d;
      s1_err_q   <= s1_err_d;
      s1_val_q   <= s1_val_d;
      s1_key_q   <= s1_key_d;
      m_valid_q  <= m_valid_d;
      m_last_q   <= m_last_d;
      m_err_q    <= m_err_d;
      m_data_q   <= m_data_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_last  = m_last_q;
  assign m_err   = m_err_q;

endmodule

// File: tb/tb_nihilist_stream_cipher.sv
// Self-checking bench for nihilist_stream_cipher against a table-based cipher model.
module tb_nihilist_stream_cipher;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_we = 1'b0;
  logic [3:0] key_addr = '0;
  logic [7:0] key_char = '0;
  logic [4:0] key_len = '0;
  logic       key_busy;
  logic       mode = 1'b0;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] s_data = '0;
  logic       s_last = 1'b0;
  logic       m_valid;
  logic       m_ready = 1'b1;
  logic [7:0] m_data;
  logic       m_last;
  logic       m_err;

  int total = 0;
  int bad   = 0;

  string      sq = "RAESBCDFGHIKLMNOPQTUVWXYZ";
  int         mk [16];
  int         mlen;
  logic [7:0] in_q [$];
  logic [7:0] exp_d [$];
  logic       exp_e [$];
  logic [7:0] got_d [$];
  logic       got_e [$];
  logic       got_l [$];
  int         acc0, out0;
  int         kw_cyc = -1;
  logic [3:0] kw_addr = '0;
  logic [7:0] kw_char = '0;
  logic [4:0] kw_len = '0;
  logic       kw_busy_seen;

  nihilist_stream_cipher #(.KEY_MAX(16)) dut (
    .clk(clk), .rst(rst), .key_we(key_we), .key_addr(key_addr), .key_char(key_char),
    .key_len(key_len), .key_busy(key_busy), .mode(mode), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .m_err(m_err)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int code_of(input logic [7:0] ch);
    logic [7:0] c;
    c = (ch == 8'h4A) ? 8'h49 : ch;
    for (int i = 0; i < 25; i++) if (sq[i] == c) return (i / 5 + 1) * 10 + i % 5 + 1;
    return -1;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) mk[i] = 11;
    mk[0] = 35; mk[1] = 13; mk[2] = 22; mk[3] = 13; mk[4] = 33; mk[5] = 21; mk[6] = 45;
    mlen = 7;
  endfunction

  function automatic void build_exp(input logic md);
    int k, kc, c, d, r, cl;
    k = 0;
    exp_d.delete();
    exp_e.delete();
    foreach (in_q[i]) begin
      kc = mk[k];
      if (!md) begin
        c = code_of(in_q[i]);
        if (c < 0) begin exp_d.push_back(8'h00); exp_e.push_back(1'b1); end
        else begin exp_d.push_back(8'(c + kc)); exp_e.push_back(1'b0); end
      end else begin
        c  = int'(in_q[i]);
        d  = c - kc;
        r  = d / 10;
        cl = d % 10;
        if (c < kc || r < 1 || r > 5 || cl < 1 || cl > 5) begin
          exp_d.push_back(8'h00); exp_e.push_back(1'b1);
        end else begin
          exp_d.push_back(sq[(r - 1) * 5 + cl - 1]); exp_e.push_back(1'b0);
        end
      end
      k = (k + 1 == mlen) ? 0 : k + 1;
    end
  endfunction

  // ---------------- drivers ----------------
  task automatic do_reset();
    rst = 1'b1; s_valid = 1'b0; key_we = 1'b0; m_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic kwrite(input logic [3:0] a, input logic [7:0] ch, input logic [4:0] l);
    int c;
    @(negedge clk);
    key_we = 1'b1; key_addr = a; key_char = ch; key_len = l;
    @(negedge clk);
    key_we = 1'b0;
    c = code_of(ch);
    mk[a] = (c < 0) ? 11 : c;
    mlen  = (l == 0) ? 1 : ((l > 16) ? 16 : int'(l));
  endtask

  // Streams in_q as one message; mode toggles randomly after the first beat.
  task automatic run(input logic md, input logic rnd);
    int idx, cyc;
    logic stall_p;
    logic [10:0] prev;
    idx = 0; cyc = 0; stall_p = 1'b0; prev = '0; acc0 = -1; out0 = -1; kw_busy_seen = 1'b0;
    got_d.delete(); got_e.delete(); got_l.delete();
    while (got_d.size() < in_q.size() && cyc < 2000) begin
      @(negedge clk);
      key_we   = (cyc == kw_cyc);
      key_addr = kw_addr; key_char = kw_char; key_len = kw_len;
      s_valid  = (idx < in_q.size());
      s_data   = s_valid ? in_q[idx] : 8'h00;
      s_last   = (idx == in_q.size() - 1);
      mode     = (idx == 0) ? md : 1'($urandom);
      m_ready  = rnd ? 1'($urandom) : 1'b1;
      #1;
      if (key_we) kw_busy_seen = key_busy;
      if (rnd && stall_p) begin
        total++;
        if ({m_valid, m_data, m_last, m_err} !== prev) begin
          bad++;
          $display("FAIL stall_hold cyc=%0d: got %h want %h", cyc, {m_valid, m_data, m_last, m_err}, prev);
        end
      end
      if (s_valid && s_ready) begin
        if (idx == 0) acc0 = cyc;
        idx++;
      end
      if (m_valid && m_ready) begin
        if (got_d.size() == 0) out0 = cyc;
        got_d.push_back(m_data); got_e.push_back(m_err); got_l.push_back(m_last);
      end
      stall_p = m_valid && !m_ready;
      prev    = {m_valid, m_data, m_last, m_err};
      cyc++;
    end
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0; key_we = 1'b0; m_ready = 1'b1;
    if (cyc >= 2000) begin
      total++; bad++;
      $display("FAIL run_timeout: got %0d beats want %0d", got_d.size(), in_q.size());
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    #1;
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL rst_m_valid: got %b want 0", m_valid); end
    total++; if (m_data !== 8'h00) begin bad++; $display("FAIL rst_m_data: got %h want 00", m_data); end
    total++; if (m_last !== 1'b0)  begin bad++; $display("FAIL rst_m_last: got %b want 0", m_last); end
    total++; if (m_err !== 1'b0)   begin bad++; $display("FAIL rst_m_err: got %b want 0", m_err); end
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL rst_s_ready: got %b want 1", s_ready); end
    total++; if (key_busy !== 1'b0) begin bad++; $display("FAIL rst_key_busy: got %b want 0", key_busy); end
  endtask

  task automatic test_hello(input string tag);
    logic [7:0] he [5];
    he = '{8'd60, 8'd26, 8'd55, 8'd46, 8'd74};
    in_q = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
    run(1'b0, 1'b0);
    total++;
    if (got_d.size() != 5) begin bad++; $display("FAIL %s_count: got %0d want 5", tag, got_d.size()); end
    for (int i = 0; i < 5 && i < got_d.size(); i++) begin
      total++;
      if (got_d[i] !== he[i] || got_e[i] !== 1'b0 || got_l[i] !== (i == 4)) begin
        bad++;
        $display("FAIL %s_beat%0d: got %0d/e%b/l%b want %0d/e0/l%b", tag, i, got_d[i], got_e[i], got_l[i], he[i], i == 4);
      end
    end
    total++;
    if (out0 - acc0 != 2) begin bad++; $display("FAIL %s_latency: got %0d want 2", tag, out0 - acc0); end
  endtask

  task automatic test_decrypt();
    logic [7:0] ex [5];
    ex = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
    in_q = '{8'd60, 8'd26, 8'd55, 8'd46, 8'd74};
    run(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (i >= got_d.size() || got_d[i] !== ex[i] || got_e[i] !== 1'b0) begin
        bad++; $display("FAIL dec_hello%0d: got %h want %h", i, (i < got_d.size()) ? got_d[i] : 8'hxx, ex[i]);
      end
    end
    in_q = '{8'h4A, 8'h41};
    run(1'b0, 1'b0);
    total++;
    if (got_d.size() != 2 || got_d[0] !== 8'd66 || got_d[1] !== 8'd25) begin
      bad++; $display("FAIL enc_ja: got %0d,%0d want 66,25", got_d[0], got_d[1]);
    end
    in_q = '{8'd66};
    run(1'b1, 1'b0);
    total++;
    if (got_d.size() != 1 || got_d[0] !== 8'h49 || got_e[0] !== 1'b0 || got_l[0] !== 1'b1) begin
      bad++; $display("FAIL dec_66: got %h want 49", got_d[0]);
    end
  endtask

  task automatic test_key_program();
    logic [7:0] ex [4];
    ex = '{8'd23, 8'd26, 8'd23, 8'd26};
    kwrite(4'd0, 8'h41, 5'd2);
    kwrite(4'd1, 8'h42, 5'd2);
    in_q = '{8'h52, 8'h52, 8'h52, 8'h52};
    run(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (i >= got_d.size() || got_d[i] !== ex[i]) begin
        bad++; $display("FAIL key_ab%0d: got %0d want %0d", i, (i < got_d.size()) ? got_d[i] : 8'hxx, ex[i]);
      end
    end
    in_q = '{8'h52};
    run(1'b0, 1'b0);
    total++;
    if (got_d.size() != 1 || got_d[0] !== 8'd23) begin bad++; $display("FAIL key_restart: got %0d want 23", got_d[0]); end
    do_reset();
  endtask

  task automatic test_wrap_err();
    in_q = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48};
    build_exp(1'b0);
    run(1'b0, 1'b0);
    total++;
    if (got_d.size() != 8 || got_d[7] !== 8'd60) begin bad++; $display("FAIL wrap_beat8: got %0d want 60", got_d[7]); end
    for (int i = 0; i < 8 && i < got_d.size(); i++) begin
      total++;
      if (got_d[i] !== exp_d[i] || got_e[i] !== exp_e[i]) begin
        bad++; $display("FAIL wrap%0d: got %0d want %0d", i, got_d[i], exp_d[i]);
      end
    end
    in_q = '{8'h31, 8'h41};
    run(1'b0, 1'b0);
    total++;
    if (got_d.size() != 2 || got_e[0] !== 1'b1 || got_d[0] !== 8'h00) begin
      bad++; $display("FAIL enc_bad_char: got %h/e%b want 00/e1", got_d[0], got_e[0]);
    end
    total++;
    if (got_d.size() != 2 || got_e[1] !== 1'b0 || got_d[1] !== 8'd25) begin
      bad++; $display("FAIL err_uses_key: got %0d want 25", got_d[1]);
    end
  endtask

  task automatic test_dec_err();
    in_q = '{8'd20};
    run(1'b1, 1'b0);
    total++;
    if (got_d.size() != 1 || got_e[0] !== 1'b1 || got_d[0] !== 8'h00) begin
      bad++; $display("FAIL dec_under: got %h/e%b want 00/e1", got_d[0], got_e[0]);
    end
    kwrite(4'd0, 8'h23, 5'd1);
    in_q = '{8'd99, 8'd22};
    run(1'b1, 1'b0);
    total++;
    if (got_d.size() != 2 || got_e[0] !== 1'b1 || got_d[0] !== 8'h00) begin
      bad++; $display("FAIL dec_88: got %h/e%b want 00/e1", got_d[0], got_e[0]);
    end
    total++;
    if (got_d.size() != 2 || got_e[1] !== 1'b0 || got_d[1] !== 8'h52) begin
      bad++; $display("FAIL dec_nonletter_key: got %h want 52", got_d[1]);
    end
    do_reset();
  endtask

  task automatic test_random_stall();
    logic [4:0] l;
    l = 5'($urandom_range(0, 16));
    for (int a = 0; a < 16; a++)
      kwrite(4'(a), ($urandom_range(0, 7) == 0) ? 8'h3F : 8'(8'h41 + $urandom_range(0, 25)), l);
    for (int pass = 0; pass < 2; pass++) begin
      in_q.delete();
      for (int i = 0; i < 40; i++) begin
        if (pass == 0) in_q.push_back(($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'(8'h41 + $urandom_range(0, 25)));
        else           in_q.push_back(8'($urandom_range(10, 115)));
      end
      build_exp(pass == 1);
      run(pass == 1, 1'b1);
      total++;
      if (got_d.size() != 40) begin bad++; $display("FAIL rnd%0d_count: got %0d want 40", pass, got_d.size()); end
      for (int i = 0; i < 40 && i < got_d.size(); i++) begin
        total++;
        if (got_d[i] !== exp_d[i] || got_e[i] !== exp_e[i] || got_l[i] !== (i == 39)) begin
          bad++;
          $display("FAIL rnd%0d_beat%0d: got %0d/e%b/l%b want %0d/e%b", pass, i, got_d[i], got_e[i], got_l[i], exp_d[i], exp_e[i]);
        end
      end
    end
    do_reset();
  endtask

  task automatic test_busy_and_rst();
    logic seen;
    kw_cyc = 1; kw_addr = 4'd0; kw_char = 8'h41; kw_len = 5'd1;
    test_hello("kw_busy");
    kw_cyc = -1;
    total++;
    if (kw_busy_seen !== 1'b1) begin bad++; $display("FAIL kw_busy_flag: got %b want 1", kw_busy_seen); end
    kwrite(4'd0, 8'h41, 5'd2);
    kwrite(4'd1, 8'h42, 5'd2);
    m_ready = 1'b1; mode = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      s_valid = 1'b1; s_data = 8'h48; s_last = 1'b0;
    end
    @(negedge clk);
    rst = 1'b1; s_valid = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (m_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_m_valid: got %b want 0", m_valid); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (m_valid) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL rst_mid_flush: got %b want 0", seen); end
    test_hello("after_rst");
  endtask

  initial begin
    model_reset();
    test_reset();
    test_hello("hello");
    test_decrypt();
    test_key_program();
    test_wrap_err();
    test_dec_err();
    test_random_stall();
    test_busy_and_rst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
